adc_capture_ctrl: RTL and testbench
===================================

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 12: sample width.
- ADDR_WIDTH, 12: buffer address width; record depth N = 2^ADDR_WIDTH.
- AUTOTRIG_CYCLES, 65535: auto-trigger timeout in clocks; used only per REQ-020.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: single clock; all logic on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- arm, in, 1: start-capture pulse.
- abort, in, 1: cancel capture or readout.
- trigger, in, 1: trigger qualifier.
- pre_len, in, ADDR_WIDTH: pre-trigger sample count; latched on accepted arm.
- sample_valid, in, 1: ADC sample strobe.
- sample_in, in, DATA_WIDTH: ADC sample.
- buf_write_en, out, 1: buffer write enable.
- buf_write_addr, out, ADDR_WIDTH: buffer write address.
- buf_data_in, out, DATA_WIDTH: buffer write data.
- buf_read_addr, out, ADDR_WIDTH: buffer read address.
- buf_data_out, in, DATA_WIDTH: buffer read data, valid one clock after buf_read_addr.
- out_valid, out, 1: readout data valid.
- out_ready, in, 1: readout sink ready.
- out_data, out, DATA_WIDTH: readout sample.
- out_last, out, 1: marks the final readout sample.
- busy, out, 1: high in any state except IDLE.
- triggered, out, 1: trigger accepted for the current record.
- auto_triggered, out, 1: present only per REQ-020.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, READOUT.
REQ-004 IDLE -> PRETRIG SHALL occur on arm; IDLE -> WAIT_TRIG SHALL occur instead when pre_len = 0; arm SHALL be ignored in any other state.
REQ-005 In PRETRIG, WAIT_TRIG and POSTTRIG, each clock with sample_valid=1 SHALL:
- drive buf_write_en=1, buf_data_in=sample_in, buf_write_addr=wptr in the same cycle (combinational passthrough);
- then increment wptr modulo N.
REQ-006 wptr SHALL be 0 on accepted arm and SHALL wrap N-1 -> 0 without a flag; buf_write_en SHALL be 0 in IDLE and READOUT.
REQ-007 PRETRIG -> WAIT_TRIG SHALL occur on the clock the pre_len-th sample is written; trigger SHALL be ignored in PRETRIG.
REQ-008 In WAIT_TRIG, trigger=1 SHALL be accepted on that clock: move to POSTTRIG, set triggered=1, latch tptr = wptr (the address of the next sample written, which is the first post-trigger sample).
REQ-009 POSTTRIG -> READOUT SHALL occur on the clock the (N - pre_len)-th post-trigger sample is written; WAIT_TRIG samples overwrite older data circularly.
REQ-010 On READOUT entry, the start address SHALL be (tptr - pre_len) mod N; exactly N samples SHALL be read in address order, wrapping modulo N.
REQ-011 Readout SHALL account for the 1-cycle buffer latency, using at most a 2-entry skid, and SHALL sustain 1 sample/clock while out_ready=1.
REQ-012 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable; no sample SHALL be dropped or duplicated.
REQ-013 out_last SHALL be 1 only with the N-th sample; its transfer (out_valid & out_ready) SHALL return the FSM to IDLE the next clock with triggered cleared.
REQ-014 abort SHALL take priority over all other inputs: next state IDLE, out_valid=0, triggered=0, skid emptied.
REQ-015 Simultaneous arm and abort in IDLE SHALL leave the FSM in IDLE.
REQ-016 busy SHALL be registered, derived from next state.

Reset
REQ-017 reset_n=0 SHALL asynchronously force state IDLE and set to 0: wptr, tptr, read counter, skid, out_valid, out_last, out_data, triggered, auto_triggered, busy.
REQ-018 Reset assertion mid-capture or mid-readout SHALL abandon the record; buffer contents SHALL NOT be cleared by this block.
REQ-019 Release of reset_n SHALL be treated as synchronous to clock; first arm SHALL be accepted the first clock after release.

Configuration
REQ-020 Macro ADC_CAPTURE_AUTOTRIG_EN:
- Defined: after AUTOTRIG_CYCLES consecutive clocks in WAIT_TRIG without trigger, the block SHALL act as if trigger=1 and set auto_triggered=1 (cleared with triggered).
- Undefined: WAIT_TRIG SHALL wait indefinitely; the auto_triggered port and timeout counter SHALL be absent.

Verification
REQ-021 The bench SHALL use ADDR_WIDTH=4 (N=16) and cover these directed scenarios:
- pre_len=4, arm, samples 0..39 every clock, trigger at sample 10 -> out_data 6..21 in order; out_last with 21; busy falls after.
- pre_len=0, arm, trigger immediately with sample 0 -> readout 0..15.
- out_ready toggled 1,0,0,1 during readout -> 16 unique in-order samples, data stable while stalled.
- Trigger asserted during PRETRIG (pre_len=8, trigger at sample 3) -> ignored; trigger at sample 20 -> readout 12..27.
- abort in POSTTRIG, then in READOUT after 5 transfers -> IDLE next clock, out_valid=0; reset_n pulse mid-POSTTRIG -> all outputs 0.
- With ADC_CAPTURE_AUTOTRIG_EN, AUTOTRIG_CYCLES=20, no trigger -> auto_triggered=1 after 20 WAIT_TRIG clocks.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - Pre/post-trigger ADC capture into a circular buffer with skid-buffered readout.
// Optional WAIT_TRIG timeout (auto-trigger) is built only when ADC_CAPTURE_AUTOTRIG_EN is defined.
module adc_capture_ctrl #(
   parameter int DATA_WIDTH      = 12,
   parameter int ADDR_WIDTH      = 12,
   parameter int AUTOTRIG_CYCLES = 65535
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trigger,
   input  logic [ADDR_WIDTH-1:0] pre_len,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_in,
   output logic                  buf_write_en,
   output logic [ADDR_WIDTH-1:0] buf_write_addr,
   output logic [DATA_WIDTH-1:0] buf_data_in,
   output logic [ADDR_WIDTH-1:0] buf_read_addr,
   input  logic [DATA_WIDTH-1:0] buf_data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  triggered
`ifdef ADC_CAPTURE_AUTOTRIG_EN
   ,
   output logic                  auto_triggered
`endif
);

   typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, READOUT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] tptr_q, tptr_d;
   logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d;
   logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic                  rd_done_q, rd_done_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  skid_valid_q, skid_valid_d;
   logic                  skid_last_q, skid_last_d;
   logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                  triggered_q, triggered_d;
   logic                  busy_q, busy_d;

   logic       wr, pop, issue, trig_eff, at_fire;
   logic [1:0] occ;

`ifdef ADC_CAPTURE_AUTOTRIG_EN
   localparam int AT_W = $clog2(AUTOTRIG_CYCLES + 1);
   logic [AT_W-1:0] at_cnt_q, at_cnt_d;
   logic            auto_trig_q, auto_trig_d;

   assign at_fire        = (state_q == WAIT_TRIG) && (at_cnt_q == AT_W'(AUTOTRIG_CYCLES - 1));
   assign auto_triggered = auto_trig_q;

   always_comb begin
      at_cnt_d    = '0;
      auto_trig_d = 1'b0;
      if (state_q == WAIT_TRIG && state_d == WAIT_TRIG) at_cnt_d = at_cnt_q + AT_W'(1);
      if (triggered_d) auto_trig_d = auto_trig_q | (at_fire & ~trigger);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         at_cnt_q    <= '0;
         auto_trig_q <= 1'b0;
      end else begin
         at_cnt_q    <= at_cnt_d;
         auto_trig_q <= auto_trig_d;
      end
   end
`else
   assign at_fire = 1'b0;
`endif

   assign wr       = (state_q inside {PRETRIG, WAIT_TRIG, POSTTRIG}) & sample_valid & ~abort;
   assign pop      = out_valid_q & out_ready;
   assign trig_eff = trigger | at_fire;
   // Reads in flight count against the two output slots so returning data always has a home.
   assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, pop};
   assign issue    = (state_q == READOUT) && !rd_done_q && (occ < 2'd2);

   assign buf_write_en   = wr;
   assign buf_write_addr = wptr_q;
   assign buf_data_in    = sample_in;
   assign buf_read_addr  = rd_addr_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_last       = out_last_q;
   assign busy           = busy_q;
   assign triggered      = triggered_q;

   always_comb begin
      state_d         = state_q;
      wptr_d          = wptr_q;
      tptr_d          = tptr_q;
      pre_len_d       = pre_len_q;
      post_cnt_d      = post_cnt_q;
      rd_addr_d       = rd_addr_q;
      rd_cnt_d        = rd_cnt_q;
      rd_done_d       = rd_done_q;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      out_valid_d     = out_valid_q;
      out_last_d      = out_last_q;
      out_data_d      = out_data_q;
      skid_valid_d    = skid_valid_q;
      skid_last_d     = skid_last_q;
      skid_data_d     = skid_data_q;

      if (wr) wptr_d = wptr_q + ADDR_WIDTH'(1);

      case (state_q)
         IDLE: if (arm) begin
            wptr_d    = '0;
            pre_len_d = pre_len;
            state_d   = (pre_len == '0) ? WAIT_TRIG : PRETRIG;
         end
         PRETRIG: if (wr && wptr_q == pre_len_q - ADDR_WIDTH'(1)) state_d = WAIT_TRIG;
         // The sample written on the trigger clock is the first post-trigger sample.
         WAIT_TRIG: if (trig_eff) begin
            tptr_d     = wptr_q;
            post_cnt_d = {{(ADDR_WIDTH-1){1'b0}}, wr};
            state_d    = (wr && (~pre_len_q == '0)) ? READOUT : POSTTRIG;
         end
         POSTTRIG: if (wr) begin
            post_cnt_d = post_cnt_q + ADDR_WIDTH'(1);
            if (post_cnt_q == ~pre_len_q) state_d = READOUT;
         end
         READOUT: if (pop && out_last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (state_q != READOUT && state_d == READOUT) begin
         rd_addr_d = tptr_d - pre_len_q;
         rd_cnt_d  = '0;
         rd_done_d = 1'b0;
      end

      if (issue) begin
         rd_addr_d       = rd_addr_q + ADDR_WIDTH'(1);
         rd_cnt_d        = rd_cnt_q + ADDR_WIDTH'(1);
         rd_done_d       = (rd_cnt_q == '1);
         inflight_d      = 1'b1;
         inflight_last_d = (rd_cnt_q == '1);
      end

      if (!out_valid_q || pop) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = inflight_q;
            skid_data_d  = buf_data_out;
            skid_last_d  = inflight_last_q;
         end else if (inflight_q) begin
            out_valid_d = 1'b1;
            out_data_d  = buf_data_out;
            out_last_d  = inflight_last_q;
         end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      end else if (inflight_q) begin
         skid_valid_d = 1'b1;
         skid_data_d  = buf_data_out;
         skid_last_d  = inflight_last_q;
      end

      if (abort) begin
         state_d      = IDLE;
         out_valid_d  = 1'b0;
         out_last_d   = 1'b0;
         skid_valid_d = 1'b0;
         inflight_d   = 1'b0;
      end

      triggered_d = (state_d == POSTTRIG) || (state_d == READOUT);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         wptr_q          <= '0;
         tptr_q          <= '0;
         pre_len_q       <= '0;
         post_cnt_q      <= '0;
         rd_addr_q       <= '0;
         rd_cnt_q        <= '0;
         rd_done_q       <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         out_valid_q     <= 1'b0;
         out_last_q      <= 1'b0;
         out_data_q      <= '0;
         skid_valid_q    <= 1'b0;
         skid_last_q     <= 1'b0;
         skid_data_q     <= '0;
         triggered_q     <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         wptr_q          <= wptr_d;
         tptr_q          <= tptr_d;
         pre_len_q       <= pre_len_d;
         post_cnt_q      <= post_cnt_d;
         rd_addr_q       <= rd_addr_d;
         rd_cnt_q        <= rd_cnt_d;
         rd_done_q       <= rd_done_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         out_valid_q     <= out_valid_d;
         out_last_q      <= out_last_d;
         out_data_q      <= out_data_d;
         skid_valid_q    <= skid_valid_d;
         skid_last_q     <= skid_last_d;
         skid_data_q     <= skid_data_d;
         triggered_q     <= triggered_d;
         busy_q          <= busy_d;
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - Self-checking bench for adc_capture_ctrl with a 16-entry buffer.
module tb_adc_capture_ctrl;
   localparam int DW = 12;
   localparam int AW = 4;
   localparam int N  = 16;
   localparam int AT = 20;

   logic          clock = 1'b0;
   logic          reset_n, arm, abort, trigger, sample_valid, out_ready;
   logic [AW-1:0] pre_len;
   logic [DW-1:0] sample_in;
   logic          buf_write_en, out_valid, out_last, busy, triggered;
   logic [AW-1:0] buf_write_addr, buf_read_addr;
   logic [DW-1:0] buf_data_in, buf_data_out, out_data;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
   logic          auto_triggered;
`endif

   always #5 clock = ~clock;

   adc_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTOTRIG_CYCLES(AT)) dut (
      .clock(clock), .reset_n(reset_n), .arm(arm), .abort(abort), .trigger(trigger),
      .pre_len(pre_len), .sample_valid(sample_valid), .sample_in(sample_in),
      .buf_write_en(buf_write_en), .buf_write_addr(buf_write_addr), .buf_data_in(buf_data_in),
      .buf_read_addr(buf_read_addr), .buf_data_out(buf_data_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .triggered(triggered)
`ifdef ADC_CAPTURE_AUTOTRIG_EN
      , .auto_triggered(auto_triggered)
`endif
   );

   // Sample buffer with one clock of read latency.
   logic [DW-1:0] mem [N];
   always @(posedge clock) begin
      if (buf_write_en) mem[buf_write_addr] <= buf_data_in;
      buf_data_out <= mem[buf_read_addr];
   end

   int errors = 0;
   int checks = 0;

   function automatic void chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Readout monitor: collects transfers and checks stability while stalled.
   bit            mon_en = 1'b0;
   bit            held_v = 1'b0;
   logic [DW-1:0] held_d;
   logic          held_l;
   int            got_q[$];
   int            exp_q[$];

   always @(negedge clock) begin
      if (mon_en && reset_n) begin
         if (held_v) begin
            chk("stall_valid", out_valid, 1);
            if (out_valid) begin
               chk("stall_data", out_data, held_d);
               chk("stall_last", out_last, held_l);
            end
         end
         held_v = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               chk("last_flag", out_last, (got_q.size() == N-1));
               got_q.push_back(int'(out_data));
            end else begin
               held_v = 1'b1;
               held_d = out_data;
               held_l = out_last;
            end
         end
      end else begin
         held_v = 1'b0;
      end
   end

   // One capture+readout; the model is the list of samples written since arm.
   // amode: 0 none, 1 abort in POSTTRIG, 2 abort after 5 transfers, 3 reset in POSTTRIG.
   task automatic run(input int pre, input int t1, input int t2, input int rmode,
                      input int amode, input int base, input bit rnd);
      int hist[$];
      int tidx = 0, nxt = 0, wcnt = 0;
      bit tacc = 0, done = 0, fin = 0;
      bit sv, tg, eff, in_wait;
      got_q.delete();
      exp_q.delete();
      held_v  = 1'b0;
      mon_en  = 1'b1;
      arm     = 1'b1;
      pre_len = AW'(pre);
      sample_valid = 1'b0;
      trigger = 1'b0;
      out_ready = 1'b0;
      @(posedge clock); #1;
      arm = 1'b0;
      chk("busy_after_arm", busy, 1);
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         sv = rnd ? ($urandom_range(3) != 0) : 1'b1;
         tg = rnd ? ($urandom_range(5) == 0) : (sv && (nxt == t1 || nxt == t2));
         sample_valid = sv;
         sample_in    = DW'(base + nxt);
         trigger      = tg;
         if (rmode == 0)      out_ready = 1'b1;
         else if (rmode == 1) out_ready = !((cyc % 4) == 1 || (cyc % 4) == 2);
         else                 out_ready = ($urandom_range(1) == 1);

         if ((amode == 1 || amode == 3) && tacc && !done && (hist.size() - tidx) == 3) begin
            mon_en = 1'b0;
            if (amode == 1) begin
               abort = 1'b1;
               @(posedge clock); #1;
               abort = 1'b0;
               chk("abort_post_busy", busy, 0);
               chk("abort_post_valid", out_valid, 0);
               chk("abort_post_trig", triggered, 0);
            end else begin
               reset_n = 1'b0;
               #1;
               chk("rst_busy", busy, 0);
               chk("rst_trig", triggered, 0);
               chk("rst_valid", out_valid, 0);
               chk("rst_last", out_last, 0);
               chk("rst_data", out_data, 0);
               chk("rst_wen", buf_write_en, 0);
               chk("rst_waddr", buf_write_addr, 0);
               chk("rst_raddr", buf_read_addr, 0);
               @(negedge clock);
               reset_n = 1'b1;
            end
            sample_valid = 1'b0;
            trigger = 1'b0;
            return;
         end
         if (amode == 2 && got_q.size() == 5) begin
            mon_en = 1'b0;
            abort = 1'b1;
            out_ready = 1'b0;
            @(posedge clock); #1;
            abort = 1'b0;
            sample_valid = 1'b0;
            trigger = 1'b0;
            chk("abort_rd_busy", busy, 0);
            chk("abort_rd_valid", out_valid, 0);
            chk("abort_rd_trig", triggered, 0);
            chk("abort_rd_count", got_q.size(), 5);
            return;
         end

         @(negedge clock);
         chk("busy_run", busy, 1);
         chk("triggered_run", triggered, tacc);
         chk("wr_en", buf_write_en, (!done && sv));
         if (!done && sv) begin
            chk("wr_addr", buf_write_addr, hist.size() % N);
            chk("wr_data", buf_data_in, base + nxt);
         end

         @(posedge clock);
         in_wait = !done && !tacc && (hist.size() >= pre);
         eff = tg;
`ifdef ADC_CAPTURE_AUTOTRIG_EN
         if (in_wait) begin
            wcnt++;
            if (wcnt == AT) eff = 1'b1;
         end
`endif
         if (in_wait && eff) begin
            tacc = 1'b1;
            tidx = hist.size();
         end
         if (!done && sv) hist.push_back(base + nxt);
         if (tacc && !done && (hist.size() - tidx) == N - pre) done = 1'b1;
         if (sv) nxt++;
         #1;
         if (got_q.size() >= N) fin = 1'b1;
      end
      sample_valid = 1'b0;
      trigger = 1'b0;
      mon_en = 1'b0;
      chk("run_complete", fin, 1);
      chk("busy_end", busy, 0);
      chk("triggered_end", triggered, 0);
      chk("valid_end", out_valid, 0);
      if (done)
         for (int i = 0; i < N; i++) exp_q.push_back(hist[tidx - pre + i]);
   endtask

   typedef struct {
      int pre;
      int t1;
      int t2;
      int rmode;
      int amode;
      int first;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{pre: 4,  t1: 10, t2: -1, rmode: 0, amode: 0, first: 6};
      tbl[1] = '{pre: 0,  t1: 0,  t2: -1, rmode: 0, amode: 0, first: 0};
      tbl[2] = '{pre: 4,  t1: 10, t2: -1, rmode: 1, amode: 0, first: 6};
      tbl[3] = '{pre: 8,  t1: 3,  t2: 20, rmode: 0, amode: 0, first: 12};
      tbl[4] = '{pre: 15, t1: 20, t2: -1, rmode: 1, amode: 0, first: 5};
      tbl[5] = '{pre: 4,  t1: 10, t2: -1, rmode: 0, amode: 1, first: 0};
      tbl[6] = '{pre: 4,  t1: 10, t2: -1, rmode: 0, amode: 2, first: 0};
      tbl[7] = '{pre: 4,  t1: 10, t2: -1, rmode: 0, amode: 3, first: 0};

      reset_n = 1'b0;
      arm = 1'b0; abort = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
      out_ready = 1'b0; pre_len = '0; sample_in = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_valid", out_valid, 0);
      chk("reset_trig", triggered, 0);
      chk("reset_wen", buf_write_en, 0);
      chk("reset_last", out_last, 0);
      @(negedge clock);
      reset_n = 1'b1;

      // Simultaneous arm and abort stays idle; samples in IDLE are not written.
      @(posedge clock); #1;
      arm = 1'b1; abort = 1'b1; pre_len = 4'd4;
      @(posedge clock); #1;
      arm = 1'b0; abort = 1'b0; sample_valid = 1'b1;
      chk("arm_abort_busy", busy, 0);
      @(negedge clock);
      chk("idle_no_write", buf_write_en, 0);
      @(posedge clock); #1;
      sample_valid = 1'b0;

      for (int r = 0; r < 8; r++) begin
         run(tbl[r].pre, tbl[r].t1, tbl[r].t2, tbl[r].rmode, tbl[r].amode, 0, 1'b0);
         if (tbl[r].amode == 0) begin
            chk("row_count", got_q.size(), N);
            for (int i = 0; i < N && i < got_q.size(); i++)
               chk($sformatf("row%0d_data%0d", r, i), got_q[i], tbl[r].first + i);
         end
      end

      for (int r = 0; r < 6; r++) begin
         run($urandom_range(N-1), -1, -1, 2, 0, 512 * (r + 1), 1'b1);
         chk("rnd_count", got_q.size(), N);
         chk("rnd_model_count", exp_q.size(), N);
         for (int i = 0; i < N && i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("rnd%0d_data%0d", r, i), got_q[i], exp_q[i]);
      end

`ifdef ADC_CAPTURE_AUTOTRIG_EN
      @(posedge clock); #1;
      arm = 1'b1; pre_len = '0;
      @(posedge clock); #1;
      arm = 1'b0;
      for (int k = 1; k <= AT; k++) begin
         sample_valid = 1'b1; trigger = 1'b0;
         @(posedge clock); #1;
         if (k >= AT - 1) chk($sformatf("auto_trig_k%0d", k), auto_triggered, (k == AT));
      end
      chk("auto_triggered_flag", triggered, 1);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0; sample_valid = 1'b0;
      chk("auto_cleared", auto_triggered, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
